// File: rtl/result_bcd_display_if.sv
// Divider-to-display result bus: divider result in, BCD conversion status out.
// The master side belongs to the divider, the slave side to result_bcd_display.
interface result_bcd_display_if;
  logic        done_in;
  logic [6:0]  Q_in;
  logic [6:0]  R_in;
  logic [11:0] bcd_q;
  logic [11:0] bcd_r;
  logic        bcd_valid;
  logic        busy;

  modport master (
    output done_in, Q_in, R_in,
    input  bcd_q, bcd_r, bcd_valid, busy
  );

  modport slave (
    input  done_in, Q_in, R_in,
    output bcd_q, bcd_r, bcd_valid, busy
  );
endinterface

// File: rtl/result_bcd_display.sv
// Divider result capture, sequential double-dabble to BCD, 4-digit mux display.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module result_bcd_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  result_bcd_display_if.slave  div,
  input  logic                 sel,
  output logic [3:0]           an,
  output logic [6:0]           seg
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state;
  logic        done_d;
  logic [6:0]  bin_q;
  logic [6:0]  bin_r;
  logic [11:0] sc_q;
  logic [11:0] sc_r;
  logic [2:0]  step;
  logic [CW-1:0] rcnt;
  logic [1:0]  idx;

  function automatic logic [18:0] dd_step(
    input logic [11:0] b,
    input logic [6:0]  x
  );
    logic [11:0] a;
    a = '0;
    for (int i = 0; i < 3; i++) begin
      if (b[i*4 +: 4] >= 4'd5)
        a[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      else
        a[i*4 +: 4] = b[i*4 +: 4];
    end
    return {a, x} << 1;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b1111111;
    unique case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic        cap;
  logic [18:0] nq;
  logic [18:0] nr;

  assign cap = div.done_in & ~done_d;
  assign nq  = dd_step(sc_q, bin_q);
  assign nr  = dd_step(sc_r, bin_r);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      done_d        <= 1'b0;
      bin_q         <= '0;
      bin_r         <= '0;
      sc_q          <= '0;
      sc_r          <= '0;
      step          <= '0;
      div.bcd_q     <= '0;
      div.bcd_r     <= '0;
      div.bcd_valid <= 1'b0;
      div.busy      <= 1'b0;
    end else begin
      done_d        <= div.done_in;
      div.bcd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cap) begin
            bin_q    <= div.Q_in;
            bin_r    <= div.R_in;
            sc_q     <= '0;
            sc_r     <= '0;
            step     <= '0;
            div.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {sc_q, bin_q} <= nq;
          {sc_r, bin_r} <= nr;
          step          <= step + 3'd1;
          if (step == 3'd6)
            state <= COMMIT;
        end
        COMMIT: begin
          div.bcd_q     <= sc_q;
          div.bcd_r     <= sc_r;
          div.bcd_valid <= 1'b1;
          div.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == CW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  logic [11:0] shown;
  logic        hz;
  logic        tz;

  assign shown = sel ? div.bcd_r : div.bcd_q;
  assign an    = ~(4'b0001 << idx);

`ifdef LEADING_ZERO_BLANK_EN
  assign hz = (shown[11:8] == 4'd0);
  assign tz = hz && (shown[7:4] == 4'd0);
`else
  assign hz = 1'b0;
  assign tz = 1'b0;
`endif

  always_comb begin
    seg = 7'b1111111;
    unique case (idx)
      2'd0: seg = enc(shown[3:0]);
      2'd1: seg = tz ? 7'b1111111 : enc(shown[7:4]);
      2'd2: seg = hz ? 7'b1111111 : enc(shown[11:8]);
      2'd3: seg = sel ? 7'b0101111 : 7'b0011000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_result_bcd_display.sv
// Self-checking bench for result_bcd_display: conversion scoreboard
// plus display scan checks with a short refresh period.
module tb_result_bcd_display;

  logic       clk;
  logic       rst;
  logic       sel;
  logic [3:0] an;
  logic [6:0] seg;

  result_bcd_display_if bus ();

  result_bcd_display #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .div (bus),
    .sel (sel),
    .an  (an),
    .seg (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] q;
    logic [11:0] r;
    int          due;
  } exp_t;

  typedef struct {
    logic [6:0]  q;
    logic [6:0]  r;
    logic [11:0] eq;
    logic [11:0] er;
    int          hold;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   valid_cnt = 0;

  localparam logic [6:0] LZ =
`ifdef LEADING_ZERO_BLANK_EN
    7'b1111111;
`else
    7'b1000000;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.bcd_valid) begin
      exp_t e;
      valid_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_valid: got q=%0h r=%0h want none",
                 bus.bcd_q, bus.bcd_r);
      end else begin
        e = sb.pop_front();
        chk("bcd_q", bus.bcd_q, e.q);
        chk("bcd_r", bus.bcd_r, e.r);
        chk("latency", cyc, e.due);
      end
    end
  end

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic run_conv(input logic [6:0] q, input logic [6:0] r,
                          input logic [11:0] eq, input logic [11:0] er,
                          input int hold);
    int nb;
    int vc;
    vc = valid_cnt;
    @(negedge clk);
    bus.Q_in = q;
    bus.R_in = r;
    bus.done_in = 1'b1;
    sb.push_back('{eq, er, cyc + 9});
    @(posedge clk);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy) nb++;
      else break;
    end
    chk("busy_len", nb, 8);
    repeat (hold) @(negedge clk);
    bus.done_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("valid_count", valid_cnt, vc + 1);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic wait_an(input logic [3:0] t);
    int n;
    n = 0;
    while (an !== t && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (an !== t) begin
      total++;
      bad++;
      $display("FAIL an_timeout: got %b want %b", an, t);
    end
  endtask

  vec_t vt[5];
  logic [6:0] exp_seg[4];

  initial begin
    int vc;
    int rv;
    vt[0] = '{7'd4,   7'd7, 12'h004, 12'h007, 11};
    vt[1] = '{7'd127, 7'd0, 12'h127, 12'h000, 0};
    vt[2] = '{7'd1,   7'd0, 12'h001, 12'h000, 0};
    vt[3] = '{7'd5,   7'd0, 12'h005, 12'h000, 0};
    vt[4] = '{7'd99,  7'd100, 12'h099, 12'h100, 1};

    rst = 1'b0;
    sel = 1'b0;
    bus.done_in = 1'b0;
    bus.Q_in = '0;
    bus.R_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_bcd_q", bus.bcd_q, 12'h000);
    chk("rst_bcd_r", bus.bcd_r, 12'h000);
    chk("rst_valid", bus.bcd_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'b1000000);
    rst = 1'b1;

    for (int i = 0; i < 5; i++)
      run_conv(vt[i].q, vt[i].r, vt[i].eq, vt[i].er, vt[i].hold);

    for (int i = 0; i < 3; i++) begin
      int a;
      a = $urandom_range(0, 127);
      rv = $urandom_range(0, 127);
      run_conv(7'(a), 7'(rv), to_bcd(a), to_bcd(rv), 0);
    end

    // retrigger attempt while busy must be ignored
    vc = valid_cnt;
    @(negedge clk);
    bus.Q_in = 7'd4;
    bus.R_in = 7'd7;
    bus.done_in = 1'b1;
    sb.push_back('{12'h004, 12'h007, cyc + 9});
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.done_in = 1'b0;
    @(negedge clk);
    bus.done_in = 1'b1;
    bus.Q_in = 7'd9;
    @(negedge clk);
    bus.done_in = 1'b0;
    repeat (14) @(negedge clk);
    chk("retrig_valid_count", valid_cnt, vc + 1);
    chk("retrig_sb_empty", sb.size(), 0);

    // reset mid-conversion aborts; done held across release recaptures
    vc = valid_cnt;
    @(negedge clk);
    bus.Q_in = 7'd50;
    bus.R_in = 7'd3;
    bus.done_in = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_bcd_q", bus.bcd_q, 12'h000);
    chk("abort_bcd_r", bus.bcd_r, 12'h000);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_valid", bus.bcd_valid, 1'b0);
    bus.Q_in = 7'd10;
    bus.R_in = 7'd0;
    repeat (2) @(negedge clk);
    chk("abort_no_valid", valid_cnt, vc);
    rst = 1'b1;
    sb.push_back('{12'h010, 12'h000, cyc + 9});
    repeat (12) @(negedge clk);
    bus.done_in = 1'b0;
    chk("post_rst_valid_count", valid_cnt, vc + 1);
    chk("post_rst_sb_empty", sb.size(), 0);

    // display scan of 127
    run_conv(7'd127, 7'd0, 12'h127, 12'h000, 0);
    sel = 1'b0;
    exp_seg[0] = 7'b1111000;
    exp_seg[1] = 7'b0100100;
    exp_seg[2] = 7'b1111001;
    exp_seg[3] = 7'b0011000;
    wait_an(4'b0111);
    wait_an(4'b1110);
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        logic [3:0] ea;
        ea = ~(4'b0001 << d);
        chk($sformatf("scan_an_d%0d", d), an, ea);
        chk($sformatf("scan_seg_d%0d", d), seg, exp_seg[d]);
        @(negedge clk);
      end
    end
    sel = 1'b1;
    wait_an(4'b0111);
    chk("ind_r", seg, 7'b0101111);
    sel = 1'b0;
    #1;
    chk("ind_q_comb", seg, 7'b0011000);
    sel = 1'b1;
    wait_an(4'b1110);
    chk("r_units", seg, 7'b1000000);
    sel = 1'b0;

    // leading zero handling on 005
    run_conv(7'd5, 7'd0, 12'h005, 12'h000, 0);
    wait_an(4'b0111);
    wait_an(4'b1110);
    chk("lz_units", seg, 7'b0010010);
    repeat (4) @(negedge clk);
    chk("lz_tens_an", an, 4'b1101);
    chk("lz_tens", seg, LZ);
    repeat (4) @(negedge clk);
    chk("lz_hund_an", an, 4'b1011);
    chk("lz_hund", seg, LZ);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_bcd_display.md
Name: result_bcd_display

Overview:
Downstream stage of the 7-bit restoring divider.
- Captures quotient Q and remainder R on the rising edge of the divider's done.
- Converts both to 3-digit BCD with a sequential double-dabble engine.
- Drives a 4-digit multiplexed 7-segment display showing the selected value plus a q/r indicator.
- Sits between the divider and the board display pins.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot (1 ms at 50 MHz); minimum 2.

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  asynchronous, active-low reset
done_in  input  1  divider done; level, may stay high
Q_in  input  7  divider quotient, valid while done_in=1
R_in  input  7  divider remainder, valid while done_in=1
sel  input  1  0 = display Q, 1 = display R
bcd_q  output  12  BCD of Q {hundreds,tens,units}
bcd_r  output  12  BCD of R
bcd_valid  output  1  one-cycle pulse when bcd_q/bcd_r update
busy  output  1  high while conversion in progress
an  output  4  digit anodes, active-low, one low at a time
seg  output  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit)

Behaviour:
Reset (rst=0, asynchronous):
- bcd_q=bcd_r=0, bcd_valid=0, busy=0, state=IDLE.
- Edge-detect register=0, refresh counter=0, digit index=0, an=4'b1110.
- seg shows the digit-0 code of value 000.

Edge detection:
- done_d registers done_in.
- Capture edge = rising clk edge with done_in=1 and done_d=0.
- done_in held high never retriggers.
- done_in already high when reset releases: treated as a new edge on the first clock after release (done_d resets to 0).

FSM states: IDLE, SHIFT, COMMIT.
- IDLE: on capture edge, latch Q_in/R_in into shift registers, clear scratch BCD, step=0, go to SHIFT, busy=1.
- SHIFT: one double-dabble step per clock, on Q and R in parallel. Each step: every BCD nibble >=5 gets +3, then shift {bcd,bin} left by 1. After step 7 (7 clocks), go to COMMIT.
- COMMIT: copy scratch to bcd_q/bcd_r, bcd_valid=1 for this one cycle, busy=0, return to IDLE.

Timing and corner cases:
- Latency: capture edge E → bcd_q/bcd_r/bcd_valid update on edge E+8.
- Capture edges while busy=1 are ignored; the in-flight result completes unchanged.
- Reset mid-conversion aborts with no bcd_valid pulse; outputs return to reset values.
- Range: inputs 0..127; hundreds nibble is 0 or 1; no overflow.

Display:
- Refresh counter counts 0..REFRESH_DIV-1. On wrap, digit index advances 0→1→2→3→0.
- an is low only at the current index.
- Digits 0, 1, 2 show units, tens and hundreds of bcd_q (sel=0) or bcd_r (sel=1).
- Digit 3 shows the indicator: 'q'=7'b0011000, 'r'=7'b0101111.
- Digit codes 0-9 are standard active-low ({g..a}: 0=7'b1000000, 1=7'b1111001, ... 9=7'b0010000).
- Blank = 7'b1111111.
- sel is combinational into the digit mux; a change is visible on the current digit immediately.
- The display always shows the last committed values, never scratch.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: hundreds digit blanks when 0. Tens digit blanks when hundreds=0 and tens=0. Units always shown.
- Undefined: all three digits always shown, including leading zeros; value 0 displays 000.
- BCD outputs are identical in both builds.

Test Plan:
1. Q=4, R=7 (127/30), done_in rises and holds 20 cycles → exactly one bcd_valid pulse, 8 edges after capture; bcd_q=12'h004, bcd_r=12'h007; busy high 8 cycles.
2. Q=127, R=0 → bcd_q=12'h127, bcd_r=12'h000. Q=1, R=0 (60/60) → 12'h001/12'h000. Q=5, R=0 (10/2) → 12'h005/12'h000.
3. Capture Q=4, R=7, pulse done_in with Q=9 at edge E+3 → result still 12'h004/12'h007; no second bcd_valid.
4. Start a conversion, drop rst at E+4 → bcd_q=bcd_r=0, no bcd_valid. After release, a new edge with Q=10 → bcd_q=12'h010.
5. REFRESH_DIV=4, bcd_q=12'h127, sel=0 → an sequence 1110,1101,1011,0111, each held 4 cycles. seg sequence 7'b1111000 ('7'), 7'b0100100 ('2'), 7'b1111001 ('1'), 7'b0011000 ('q'). With sel=1, digit 3 = 7'b0101111.
6. bcd_q=12'h005 with LEADING_ZERO_BLANK_EN defined → digits 2 and 1 show 7'b1111111, digit 0 shows 7'b0010010. Without the macro, digits 2 and 1 show 7'b1000000.
